// File: rtl/mul_seq_ctl.sv
// mul_seq_ctl: sequencing controller for the EX-stage multi-cycle multiplier
// and the HiLo register pair. It loads the operands, steps the multiplier for
// MUL_CYCLES cycles and then commits the product with a single HiLo write.
// The front of the pipeline is stalled only when a dependent instruction
// (another multiply, or an mfhi/mflo) reaches EX while a multiply is in flight.
module mul_seq_ctl #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        start,
  input  logic        mf_req,
  input  logic        flush,
  output logic        mul_load,
  output logic        mul_step,
  output logic        hilo_we,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [15:0] mul_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    WRITE = 2'd3
  } state_t;

  // The step counter counts down from MUL_CYCLES-1 to 0, so RUN lasts
  // exactly MUL_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        mul_count_q, mul_count_d;
  logic               load_q, load_d;
  logic               step_q, step_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;

  // Saturating increment for the commit counter: holds at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_count_d = mul_count_q;
    case (state_q)
      IDLE: begin
        // A flush in the same cycle as start kills the multiply before LOAD.
        if (start && !flush) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = RUN;
          cnt_d   = CNT_LOAD;
        end
      end
      RUN: begin
        // Flush takes priority over the natural exit to WRITE.
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE: begin
        // The product is committed regardless of flush in this cycle.
        state_d     = IDLE;
        mul_count_d = sat_inc16(mul_count_q);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Moore outputs are decoded from the next state and registered, so the
    // ports are glitch-free and depend on state only.
    load_d = (state_d == LOAD);
    step_d = (state_d == RUN);
    we_d   = (state_d == WRITE);
    busy_d = (state_d != IDLE);
  end

  // State, counter, commit count and registered outputs; async reset to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_count_q <= 16'd0;
      load_q      <= 1'b0;
      step_q      <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_count_q <= mul_count_d;
      load_q      <= load_d;
      step_q      <= step_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
    end
  end

  assign mul_load  = load_q;
  assign mul_step  = step_q;
  assign hilo_we   = we_q;
  assign done      = we_q;
  assign busy      = busy_q;
  assign mul_count = mul_count_q;

  // Only dependent instructions are held; busy_q is 0 during reset, which
  // also keeps unknown request inputs from reaching the stall output.
  assign stall = busy_q & (start | mf_req);

endmodule

// File: tb/tb_mul_seq_ctl.sv
// Testbench for mul_seq_ctl: three instances (MUL_CYCLES = 32, 8, 1) share
// one directed stimulus stream. A cycle-age model predicts every output on
// every cycle; literal expectations pin the model to known latencies.
module tb_mul_seq_ctl;

  localparam int MC [3] = '{32, 8, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mf_req = 1'b0;
  logic flush = 1'b0;
  logic force_now = 1'b0;
  logic chk_en = 1'b0;

  logic        ld [3];
  logic        st [3];
  logic        we [3];
  logic        dn [3];
  logic        bz [3];
  logic        sl [3];
  logic [15:0] ct [3];

  int vectors = 0;
  int errors  = 0;

  // Model: age = cycles since the multiply was accepted (0 = idle).
  int          age   [3] = '{0, 0, 0};
  logic [15:0] cnt_m [3] = '{16'd0, 16'd0, 16'd0};

  // Scenario observations (instance 0 unless indexed).
  int   first_ld [3];
  int   second_ld;
  int   steps [3];
  int   first_we [3];
  int   we_n [3];
  int   idle_at;
  int   stall_n;
  logic stall_log [0:127];

  always #5 clk = ~clk;

  mul_seq_ctl #(.MUL_CYCLES(32), .CNT_W(6)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .mf_req(mf_req), .flush(flush),
    .mul_load(ld[0]), .mul_step(st[0]), .hilo_we(we[0]), .stall(sl[0]),
    .busy(bz[0]), .done(dn[0]), .mul_count(ct[0]));

  mul_seq_ctl #(.MUL_CYCLES(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .mf_req(mf_req), .flush(flush),
    .mul_load(ld[1]), .mul_step(st[1]), .hilo_we(we[1]), .stall(sl[1]),
    .busy(bz[1]), .done(dn[1]), .mul_count(ct[1]));

  mul_seq_ctl #(.MUL_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mf_req(mf_req), .flush(flush),
    .mul_load(ld[2]), .mul_step(st[2]), .hilo_we(we[2]), .stall(sl[2]),
    .busy(bz[2]), .done(dn[2]), .mul_count(ct[2]));

  // Behavioural model: accept, age through load/steps/write, flush or commit.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        age[i]   <= 0;
        cnt_m[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (age[i] == 0) begin
          if (start && !flush) age[i] <= 1;
        end else if (age[i] == MC[i] + 2) begin
          age[i] <= 0;
          if (cnt_m[i] != 16'hFFFF) cnt_m[i] <= cnt_m[i] + 16'd1;
        end else if (flush) begin
          age[i] <= 0;
        end else begin
          age[i] <= age[i] + 1;
        end
      end
      if (force_now) cnt_m[0] <= 16'hFFFF;
    end
  end

  // Per-cycle comparison of all outputs of all instances against the model.
  always @(negedge clk) begin : cmp
    logic [21:0] o, e;
    logic        b;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        b = (age[i] != 0);
        o = {ld[i], st[i], we[i], dn[i], bz[i], sl[i], ct[i]};
        e = {age[i] == 1, (age[i] >= 2) && (age[i] <= MC[i] + 1),
             age[i] == MC[i] + 2, age[i] == MC[i] + 2, b,
             b & (start | mf_req), cnt_m[i]};
        vectors++;
        if (o !== e) begin
          errors++;
          $display("FAIL model_cmp inst=%0d t=%0t got=%h want=%h", i, $time, o, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs cycles 0..ncyc from the current cycle. start held in 0..start_to,
  // mf_req in mf_from..mf_to, flush pulsed in flush_cyc.
  task automatic scen(input int ncyc, input int start_to, input int mf_from,
                      input int mf_to, input int flush_cyc);
    second_ld = -1;
    idle_at   = -1;
    stall_n   = 0;
    for (int i = 0; i < 3; i++) begin
      first_ld[i] = -1;
      steps[i]    = 0;
      first_we[i] = -1;
      we_n[i]     = 0;
    end
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) tick();
      start  = (c <= start_to);
      mf_req = (c >= mf_from) && (c <= mf_to);
      flush  = (c == flush_cyc);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (ld[i]) begin
          if (first_ld[i] < 0) first_ld[i] = c;
          else if (i == 0 && second_ld < 0) second_ld = c;
        end
        if (st[i]) steps[i]++;
        if (we[i]) begin
          we_n[i]++;
          if (first_we[i] < 0) first_we[i] = c;
        end
      end
      if (c >= 1 && !bz[0] && idle_at < 0) idle_at = c;
      if (sl[0]) stall_n++;
      if (c < 128) stall_log[c] = sl[0];
    end
    start  = 1'b0;
    mf_req = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_outs"}, int'({ld[0], st[0], we[0], dn[0], bz[0], sl[0]}), 0);
    chk({nm, "_count"}, int'(ct[0]), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random request inputs.
    #3 rst = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      start  = 1'($urandom_range(0, 1));
      mf_req = 1'($urandom_range(0, 1));
      flush  = 1'($urandom_range(0, 1));
      #1 chk_all_zero("reset");
    end
    tick();
    start = 1'b0; mf_req = 1'b0; flush = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    // Single multiply: latency on all three parameterisations.
    scen(36, 0, -1, -1, -1);
    chk("s1_load_cyc", first_ld[0], 1);
    chk("s1_steps32", steps[0], 32);
    chk("s1_we_cyc32", first_we[0], 34);
    chk("s1_idle_cyc", idle_at, 35);
    chk("s1_steps8", steps[1], 8);
    chk("s1_we_cyc8", first_we[1], 10);
    chk("s1_steps1", steps[2], 1);
    chk("s1_we_cyc1", first_we[2], 3);
    chk("s1_count", int'(ct[0]), 1);
    tick();

    // Dependent mfhi/mflo held from cycle 5.
    scen(36, 0, 5, 36, -1);
    chk("s2_stall_indep", int'(stall_log[3]), 0);
    chk("s2_stall_write", int'(stall_log[34]), 1);
    chk("s2_stall_release", int'(stall_log[35]), 0);
    chk("s2_stall_cycles", stall_n, 30);
    chk("s2_count", int'(ct[0]), 2);
    tick();

    // Back-to-back: start held until the second multiply is accepted.
    scen(71, 35, -1, -1, -1);
    chk("s3_load1", first_ld[0], 1);
    chk("s3_load2", second_ld, 36);
    chk("s3_stall_cycles", stall_n, 34);
    chk("s3_we_n", we_n[0], 2);
    chk("s3_count", int'(ct[0]), 4);
    tick();

    // Flush during LOAD.
    scen(6, 0, -1, -1, 1);
    chk("s4a_steps", steps[0], 0);
    chk("s4a_idle_cyc", idle_at, 2);
    chk("s4a_count", int'(ct[0]), 4);
    tick();

    // Flush in RUN.
    scen(40, 0, -1, -1, 12);
    chk("s4b_steps", steps[0], 11);
    chk("s4b_idle_cyc", idle_at, 13);
    chk("s4b_we_n", we_n[0], 0);
    chk("s4b_count", int'(ct[0]), 4);
    tick();

    // Flush in WRITE still commits.
    scen(36, 0, -1, -1, 34);
    chk("s4c_we_cyc", first_we[0], 34);
    chk("s4c_count", int'(ct[0]), 5);
    tick();

    // Flush together with start in IDLE.
    scen(3, 0, -1, -1, 0);
    chk("s4d_load", first_ld[0], -1);
    chk("s4d_idle_cyc", idle_at, 1);
    chk("s4d_count", int'(ct[0]), 5);
    tick();

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 20; c++) tick();
    #1 chk("s5_step_before", int'(st[0]), 1);
    rst = 1'b0;
    #1 chk_all_zero("s5_async");
    for (int k = 0; k < 2; k++) begin
      tick();
      start  = 1'($urandom_range(0, 1));
      mf_req = 1'($urandom_range(0, 1));
      flush  = 1'($urandom_range(0, 1));
      #1 chk_all_zero("s5_hold");
    end
    tick();
    start = 1'b0; mf_req = 1'b0; flush = 1'b0;
    rst = 1'b1;
    tick();
    scen(36, 0, -1, -1, -1);
    chk("s5_load_cyc", first_ld[0], 1);
    chk("s5_we_cyc", first_we[0], 34);
    chk("s5_steps", steps[0], 32);
    chk("s5_count", int'(ct[0]), 1);
    tick();

    // Saturation of the commit counter.
    force u_dut32.mul_count_d = 16'hFFFF;
    force_now = 1'b1;
    tick();
    release u_dut32.mul_count_d;
    force_now = 1'b0;
    #1 chk("s6_preset", int'(ct[0]), 65535);
    scen(36, 0, -1, -1, -1);
    chk("s6_we_cyc", first_we[0], 34);
    chk("s6_count_sat", int'(ct[0]), 65535);
    tick();
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
